// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed, checksummed byte stream, packs it
// into big-endian 32-bit words, writes them to CPU memory and releases the
// CPU from reset only after the whole image checks out.
module boot_loader #(
  parameter int unsigned WORDS = 64,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  logic [15:0] r_n;
  logic [15:0] r_widx;
  logic [1:0]  r_bidx;
  logic [23:0] r_word;
  logic [7:0]  r_sum;

  logic        w_ready;
  logic        w_accept;
  logic [15:0] w_n_next;
  logic [31:0] w_word_next;
  logic [15:0] w_widx_inc;
  logic [31:0] w_addr;

  // Ready is a pure function of state; reset overrides it the same cycle.
  always_comb begin
    w_ready = 1'b0;
    unique case (r_state)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: w_ready = 1'b1;
      default:                            w_ready = 1'b0;
    endcase
  end

  assign byte_ready  = w_ready & ~reset;
  assign w_accept    = byte_valid & byte_ready;
  assign w_n_next    = {r_n[15:8], byte_data};
  // Only the low 24 bits of the shift register survive into the next word.
  assign w_word_next = {r_word, byte_data};
  assign w_widx_inc  = r_widx + 16'd1;
  assign w_addr      = BASE + {14'd0, r_widx, 2'b00};

  // Frame-parsing FSM with registered memory-write and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_LEN_HI;
      r_n       <= '0;
      r_widx    <= '0;
      r_bidx    <= '0;
      r_word    <= '0;
      r_sum     <= '0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_wr <= 1'b0;
      unique case (r_state)
        S_LEN_HI: begin
          if (w_accept) begin
            r_n     <= {byte_data, 8'd0};
            r_sum   <= r_sum + byte_data;
            r_state <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_n    <= w_n_next;
            r_sum  <= r_sum + byte_data;
            r_widx <= '0;
            r_bidx <= '0;
            if (32'(w_n_next) > WORDS) begin
              r_state <= S_ERR;
              error   <= 1'b1;
            end else if (w_n_next == 16'd0) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_word <= w_word_next[23:0];
            r_sum  <= r_sum + byte_data;
            r_bidx <= r_bidx + 2'd1;
            if (r_bidx == 2'd3) begin
              r_state   <= S_WRITE;
              mem_wr    <= 1'b1;
              mem_addr  <= w_addr;
              mem_wdata <= w_word_next;
            end
          end
        end
        S_WRITE: begin
          r_widx <= w_widx_inc;
          r_bidx <= '0;
          if (w_widx_inc == r_n) r_state <= S_CSUM;
          else                   r_state <= S_DATA;
        end
        S_CSUM: begin
          if (w_accept) begin
            if (byte_data == r_sum) begin
              r_state   <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              r_state <= S_ERR;
              error   <= 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_DONE;
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Testbench for boot_loader: directed frame table, a mid-load reset sequence
// and randomized frames checked against a stream-level reference model.
module tb_boot_loader;

  localparam int unsigned WORDS_P = 64;
  localparam logic [31:0] BASE_P  = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  boot_loader #(.WORDS(WORDS_P), .BASE(BASE_P)) dut (
    .clock      (clock),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [95:0] b;      // stream bytes, first byte in bits [95:88]
    int          len;
    int          thr;    // percent chance byte_valid is asserted per cycle
    bit          ed;     // expected done
    bit          ee;     // expected error
    int          nwr;    // expected number of memory writes
  } vec_t;

  logic [7:0] stim[$];
  wr_t        exp_wr[$];
  wr_t        got_wr[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  // Capture every write strobe seen by the memory.
  always @(negedge clock) begin
    if (mem_wr === 1'b1) got_wr.push_back('{mem_addr, mem_wdata});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b1;
    byte_valid = 1'b0;
    @(negedge clock);
    #1;
    chk("ready_in_reset", {31'd0, byte_ready}, 32'd0);
    reset = 1'b0;
    got_wr.delete();
  endtask

  // Offer stim[] with random throttling; check ready, completion timing,
  // final status, consumption count and the written words.
  task automatic run_frame(input int thr, input string tag);
    int         n, acc_total, p, cyc, settle, prev_pos;
    bit         exp_done, prev_acc, exp_rdy;
    logic [7:0] sum;
    exp_wr.delete();
    n = int'({stim[0], stim[1]});
    if (n > int'(WORDS_P)) begin
      acc_total = 2;
      exp_done  = 1'b0;
    end else begin
      acc_total = 3 + 4 * n;
      sum = 8'd0;
      for (int i = 0; i < 2 + 4 * n; i++) sum = sum + stim[i];
      for (int w = 0; w < n; w++)
        exp_wr.push_back('{BASE_P + 32'(4 * w),
                           {stim[2+4*w], stim[3+4*w], stim[4+4*w], stim[5+4*w]}});
      exp_done = (stim[2 + 4 * n] == sum);
    end

    p = 0; cyc = 0; settle = 0; prev_acc = 1'b0; prev_pos = 0;
    while (settle < 4 && cyc < 4000) begin
      @(negedge clock);
      cyc++;
      if (prev_acc && prev_pos == acc_total - 1) begin
        chk({tag, "_done"},  {31'd0, done},      {31'd0, exp_done});
        chk({tag, "_error"}, {31'd0, error},     {31'd0, !exp_done});
        chk({tag, "_cpurst"}, {31'd0, cpu_reset}, {31'd0, !exp_done});
      end
      byte_valid = (p < stim.size()) && ($urandom_range(99) < thr);
      byte_data  = byte_valid ? stim[p] : 8'($urandom);
      #1;
      // A word's 4th data byte is always followed by one non-ready cycle.
      exp_rdy = (p < acc_total) &&
                !(prev_acc && prev_pos >= 2 && prev_pos < acc_total - 1 &&
                  ((prev_pos - 2) % 4 == 3));
      chk({tag, "_ready"}, {31'd0, byte_ready}, {31'd0, exp_rdy});
      if (byte_valid && byte_ready && p == acc_total - 1) begin
        chk({tag, "_pre_done"},  {31'd0, done},      32'd0);
        chk({tag, "_pre_error"}, {31'd0, error},     32'd0);
        chk({tag, "_pre_cpurst"}, {31'd0, cpu_reset}, 32'd1);
      end
      prev_acc = byte_valid && byte_ready;
      if (prev_acc) begin
        prev_pos = p;
        p++;
      end
      if (p >= acc_total) settle++;
    end
    byte_valid = 1'b0;
    if (settle < 4) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_consumed"}, 32'(p), 32'(acc_total));
    chk({tag, "_nwrites"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      chk({tag, "_waddr"}, got_wr[i].addr, exp_wr[i].addr);
      chk({tag, "_wdata"}, got_wr[i].data, exp_wr[i].data);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [95:0] tmp;
    int          nw;
    logic [7:0]  s;
    logic [7:0]  valid_img[11];

    vecs[0] = '{96'h00021234_5678DEAD_BEEF4E00, 11, 100, 1'b1, 1'b0, 2};
    vecs[1] = '{96'h00000000_00000000_00000000,  3, 100, 1'b1, 1'b0, 0};
    vecs[2] = '{96'h00021234_5678DEAD_BEEF4F00, 11, 100, 1'b0, 1'b1, 2};
    vecs[3] = '{96'h00410000_00000000_00000000,  2, 100, 1'b0, 1'b1, 0};
    vecs[4] = '{96'h00021234_5678DEAD_BEEF4E00, 11,  45, 1'b1, 1'b0, 2};
    vecs[5] = '{96'h01000000_00000000_00000000,  2,  70, 1'b0, 1'b1, 0};

    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    repeat (3) @(negedge clock);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_addr",   mem_addr,        32'd0);
    chk("rst_wdata",  mem_wdata,       32'd0);
    chk("rst_cpurst", {31'd0, cpu_reset}, 32'd1);
    chk("rst_done",   {31'd0, done},   32'd0);
    chk("rst_error",  {31'd0, error},  32'd0);
    chk("rst_ready",  {31'd0, byte_ready}, 32'd0);

    // Directed frames: table expectations plus model-level checks.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      stim.delete();
      tmp = vecs[v].b;
      for (int i = 0; i < vecs[v].len; i++) stim.push_back(tmp[95 - 8*i -: 8]);
      stim.push_back(8'hA5);
      run_frame(vecs[v].thr, "vec");
      chk("vec_tbl_done",  {31'd0, done},  {31'd0, vecs[v].ed});
      chk("vec_tbl_error", {31'd0, error}, {31'd0, vecs[v].ee});
      chk("vec_tbl_nwr",   32'(got_wr.size()), 32'(vecs[v].nwr));
    end

    // Reset after 6 bytes of the valid image, then reload it.
    tmp = vecs[0].b;
    for (int i = 0; i < 11; i++) valid_img[i] = tmp[95 - 8*i -: 8];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      byte_valid = 1'b1;
      byte_data  = valid_img[i];
    end
    @(negedge clock);
    reset      = 1'b1;
    byte_data  = valid_img[6];
    #1;
    chk("mid_ready_forced", {31'd0, byte_ready}, 32'd0);
    @(negedge clock);
    reset      = 1'b0;
    byte_valid = 1'b0;
    chk("mid_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("mid_addr",   mem_addr,        32'd0);
    chk("mid_wdata",  mem_wdata,       32'd0);
    chk("mid_cpurst", {31'd0, cpu_reset}, 32'd1);
    chk("mid_done",   {31'd0, done},   32'd0);
    chk("mid_error",  {31'd0, error},  32'd0);
    got_wr.delete();
    stim.delete();
    for (int i = 0; i < 11; i++) stim.push_back(valid_img[i]);
    stim.push_back(8'h3C);
    run_frame(100, "reload");
    chk("reload_done", {31'd0, done}, 32'd1);

    // Randomized frames, including the N == WORDS / WORDS+1 boundary.
    for (int f = 0; f < 24; f++) begin
      case ($urandom_range(5))
        0:       nw = int'(WORDS_P);
        1:       nw = int'(WORDS_P) + 1;
        2:       nw = int'($urandom_range(65535, 256));
        default: nw = int'($urandom_range(6));
      endcase
      stim.delete();
      stim.push_back(8'(nw >> 8));
      stim.push_back(8'(nw));
      if (nw <= int'(WORDS_P)) begin
        s = 8'(nw >> 8) + 8'(nw);
        for (int i = 0; i < 4 * nw; i++) begin
          stim.push_back(8'($urandom));
          s = s + stim[stim.size() - 1];
        end
        if ($urandom_range(3) == 0) s = s + 8'($urandom_range(255, 1));
        stim.push_back(s);
      end
      stim.push_back(8'($urandom));
      do_reset();
      run_frame(int'($urandom_range(100, 30)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
